// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
// Instruction layout, fetch FSM states and reset defaults.
package fetch_unit_pkg;

    localparam int IMM_FLAG_BIT = 27;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        S_OP,
        S_IMM,
        S_HOLD
    } fetch_state_t;

    // Opcode word in the upper half, trailing immediate in the lower half.
    typedef struct packed {
        logic [30-IMM_FLAG_BIT:0] op_hi;
        logic                     imm_valid;
        logic [IMM_FLAG_BIT-17:0] op_lo;
        logic [15:0]              imm;
    } instr_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: opcode plus optional immediate over a
// req/ack memory port, held for the core until it supplies the next pc.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMM_BIT  = IMM_FLAG_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] instr_ip,
    input  logic        next_valid,
    input  logic [15:0] next_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pc_inc;
    instr_t       instr_q;
    logic         take;

    // An ack only counts while a request is actually outstanding.
    assign take     = mem_req && mem_ack;
    assign pc_inc   = pc + 16'd1;
    assign mem_addr = (state == S_IMM) ? pc_inc : pc;
    assign instr    = instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_OP;
            pc          <= RESET_PC;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            instr_q     <= '0;
            instr_ip    <= '0;
            fetch_count <= '0;
        end else begin
            unique case (state)
                S_OP: begin
                    if (take) begin
                        instr_q[31:16] <= mem_rdata;
                        instr_ip       <= pc;
                        if (mem_rdata[IMM_BIT-16]) begin
                            mem_req <= 1'b1;
                            state   <= S_IMM;
                        end else begin
                            instr_q.imm <= '0;
                            mem_req     <= 1'b0;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                S_IMM: begin
                    if (take) begin
                        instr_q.imm <= mem_rdata;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (next_valid) begin
                        pc          <= next_pc;
                        mem_req     <= 1'b1;
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + 32'd1;
                        state       <= S_OP;
                    end
                end
                default: begin
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= S_OP;
                end
            endcase
        end
    end

endmodule
